// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: state encoding shared by the pipeline stage register and its users
package pipe_stage_reg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stage handshake carrying split control and payload fields
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  modport master (output valid, ctrl, data, input ready);
  modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= clr ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry, flush and bubble counter
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter int SKID_EN    = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [1:0]        occupancy,
  input  logic              bubble_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam bit WIPE = CLEAR_DATA != 0;
  state_t            st, st_nx;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              acc, rel, load_in, load_skid, kill_head;
  assign dn.valid  = st != ST_EMPTY;
  assign dn.ctrl   = head_ctrl;
  assign dn.data   = head_data;
  assign occupancy = st;
  assign acc       = up.valid && up.ready;
  assign rel       = dn.valid && dn.ready;
  always_comb begin
    st_nx = flush ? ST_EMPTY
          : st == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY)
          : st == ST_TWO ? (rel ? ST_ONE : ST_TWO)
          : (SKID_EN != 0 && acc && !rel) ? ST_TWO
          : (rel && !acc) ? ST_EMPTY : ST_ONE;
    load_in   = !flush && acc && (st == ST_EMPTY || rel);
    load_skid = !flush && st == ST_TWO && rel;
    kill_head = flush || (st == ST_ONE && rel && !acc);
  end
  // head ctrl is zeroed whenever the stage empties, so bubbles never carry live control
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st        <= ST_EMPTY;
      head_ctrl <= '0;
      head_data <= '0;
    end else begin
      st        <= st_nx;
      head_ctrl <= kill_head ? '0 : load_in ? up.ctrl : load_skid ? skid_ctrl : head_ctrl;
      head_data <= (kill_head && WIPE) ? '0 : load_in ? up.data : load_skid ? skid_data : head_data;
    end
  if (SKID_EN != 0) begin : g_skid
    logic rdy;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        rdy       <= 1'b1;
        skid_ctrl <= '0;
        skid_data <= '0;
      end else begin
        rdy       <= st_nx != ST_TWO;
        skid_ctrl <= flush ? '0 : (st == ST_ONE && acc && !rel) ? up.ctrl : skid_ctrl;
        skid_data <= (flush && WIPE) ? '0 : (!flush && st == ST_ONE && acc && !rel) ? up.data : skid_data;
      end
    assign up.ready = rdy;
  end else begin : g_noskid
    assign skid_ctrl = '0;
    assign skid_data = '0;
    assign up.ready  = !dn.valid || dn.ready;
  end
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk   (clk),
    .reset (reset),
    .en    (dn.ready && !dn.valid),
    .clr   (bubble_clr),
    .q     (bubble_cnt)
  );
endmodule
